// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT stage/butterfly sequencer: issues operand indices and twiddle addresses,
// draining outstanding write-backs at every stage boundary. Optional macro: FFT_SEQ_INVERSE_EN.
module fft_stage_sequencer #(
    parameter  int unsigned N     = 8,
    parameter  int unsigned OUT_W = 3,
    localparam int unsigned LOG2N = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     bf_valid,
    input  logic                     bf_ready,
    output logic [LOG2N-1:0]         idx_a,
    output logic [LOG2N-1:0]         idx_b,
    output logic [LOG2N-2:0]         tw_addr,
    output logic [$clog2(LOG2N)-1:0] stage,
    input  logic                     wb_done
`ifdef FFT_SEQ_INVERSE_EN
    ,
    input  logic                     inverse,
    output logic                     tw_conj
`endif
);

    localparam int unsigned SW  = $clog2(LOG2N);
    localparam int unsigned KW  = LOG2N - 1;
    localparam int unsigned TWW = LOG2N - 1;
    localparam int unsigned AW  = 2 * LOG2N + TWW;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      s_q, s_d;
    logic [KW-1:0]      k_q, k_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [LOG2N-1:0]   a_q, a_d, b_q, b_d;
    logic [TWW-1:0]     tw_q, tw_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               hs;
    logic               accept;

    // Packed {idx_a, idx_b, tw_addr} for butterfly k of stage s.
    function automatic logic [AW-1:0] bf_addr(input int unsigned s, input int unsigned k);
        int unsigned half, pos, grp, a, b, tw;
        half = 1 << s;
        pos  = k & (half - 1);
        grp  = k >> s;
        a    = grp * 2 * half + pos;
        b    = a + half;
        tw   = pos << (LOG2N - 1 - s);
        return {LOG2N'(a), LOG2N'(b), TWW'(tw)};
    endfunction

    assign hs     = (state_q == ISSUE) && valid_q && bf_ready;
    assign accept = (state_q == IDLE) && start && !abort;

    always_comb begin
        out_d = out_q;
        if (hs && !wb_done)
            out_d = out_q + 1'b1;
        else if (!hs && wb_done && (out_q != '0))
            out_d = out_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        tw_d    = tw_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d           = ISSUE;
                    s_d               = '0;
                    k_d               = '0;
                    valid_d           = 1'b1;
                    {a_d, b_d, tw_d}  = bf_addr(0, 0);
                end
            end
            ISSUE: begin
                if (hs) begin
                    if (k_q == KW'(N / 2 - 1)) begin
                        state_d = DRAIN;
                        valid_d = 1'b0;
                    end else begin
                        k_d              = k_q + 1'b1;
                        {a_d, b_d, tw_d} = bf_addr(32'(s_q), 32'(k_q) + 1);
                    end
                end
            end
            DRAIN: begin
                // A write-back landing this very cycle already counts as drained.
                if (out_d == '0) begin
                    if (s_q == SW'(LOG2N - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d          = ISSUE;
                        s_d              = s_q + 1'b1;
                        k_d              = '0;
                        valid_d          = 1'b1;
                        {a_d, b_d, tw_d} = bf_addr(32'(s_q) + 1, 0);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                s_d     = '0;
                k_d     = '0;
                a_d     = '0;
                b_d     = '0;
                tw_d    = '0;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            s_d     = '0;
            k_d     = '0;
            a_d     = '0;
            b_d     = '0;
            tw_d    = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            out_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tw_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            out_q   <= abort ? '0 : out_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tw_q    <= tw_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bf_valid = valid_q;
    assign idx_a    = a_q;
    assign idx_b    = b_q;
    assign tw_addr  = tw_q;
    assign stage    = s_q;

`ifdef FFT_SEQ_INVERSE_EN
    logic conj_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conj_q <= 1'b0;
        else if (accept)
            conj_q <= inverse;
    end

    assign tw_conj = conj_q;
`endif

endmodule
